// File: rtl/lsu_split_if.sv
// Bundle of the load/store unit's core-side request/response and data-memory beat signals.
// The slave modport is the unit's own view; master is the core plus memory environment.
interface lsu_split_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_type_i;
   logic                  req_sign_extend_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [31:0]           req_wdata_i;
   logic                  resp_valid_o;
   logic [31:0]           resp_rdata_o;
   logic                  resp_err_o;
   logic [1:0]            resp_err_cause_o;
   logic                  dmem_valid_o;
   logic                  dmem_ready_i;
   logic [ADDR_WIDTH-1:0] dmem_addr_o;
   logic [31:0]           dmem_wdata_o;
   logic [3:0]            dmem_we_o;
   logic [31:0]           dmem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_type_i, req_sign_extend_i, req_addr_i, req_wdata_i,
             dmem_ready_i, dmem_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_err_cause_o,
             dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o
   );

   modport master (
      output req_valid_i, req_we_i, req_type_i, req_sign_extend_i, req_addr_i, req_wdata_i,
             dmem_ready_i, dmem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_err_cause_o,
             dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o
   );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit: one request at a time, word-aligned memory beats, optional splitting of
// word-crossing accesses into two beats with reassembly, and a per-beat bus timeout.
module lsu_split #(
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter bit          SPLIT_MISALIGNED = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES   = 0
) (
   input logic        clk_i,
   input logic        rst_ni,
   lsu_split_if.slave bus
);
   localparam logic [1:0] DATA_WORD      = 2'b00;
   localparam logic [1:0] DATA_HALF_WORD = 2'b01;
   localparam logic [1:0] DATA_BYTE      = 2'b10;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
   localparam logic [1:0] CAUSE_INVALID  = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

   function automatic logic [7:0] lane_mask(input logic [1:0] typ, input logic [1:0] k);
      logic [7:0] m;
      case (typ)
         DATA_BYTE:      m = 8'h01;
         DATA_HALF_WORD: m = 8'h03;
         DATA_WORD:      m = 8'h0F;
         default:        m = 8'h00;
      endcase
      return m << k;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w, input logic [1:0] k);
      logic [31:0] r;
      case (k)
         2'd0:    r = w;
         2'd1:    r = {w[23:0], w[31:24]};
         2'd2:    r = {w[15:0], w[31:16]};
         2'd3:    r = {w[7:0], w[31:8]};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] hi, input logic [31:0] lo,
                                                input logic [1:0] k, input logic [1:0] typ,
                                                input logic sext);
      logic [63:0] sh;
      logic [31:0] r;
      sh = {hi, lo} >> {k, 3'b000};
      case (typ)
         DATA_BYTE:      r = {{24{sext & sh[7]}}, sh[7:0]};
         DATA_HALF_WORD: r = {{16{sext & sh[15]}}, sh[15:0]};
         DATA_WORD:      r = sh[31:0];
         default:        r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   state_t                state_r, state_s;
   logic                  we_r, we_s, sext_r, sext_s;
   logic [1:0]            type_r, type_s, k_r, k_s;
   logic [7:0]            mask_r, mask_s, acc_mask_s;
   logic [ADDR_WIDTH-1:0] base_r, base_s, acc_base_s;
   logic [31:0]           rd0_r, rd0_s, tcnt_r, tcnt_s, acc_wrot_s;
   logic                  dmem_valid_r, dmem_valid_s;
   logic [ADDR_WIDTH-1:0] dmem_addr_r, dmem_addr_s;
   logic [31:0]           dmem_wdata_r, dmem_wdata_s;
   logic [3:0]            dmem_we_r, dmem_we_s;
   logic                  resp_valid_r, resp_valid_s, resp_err_r, resp_err_s;
   logic [31:0]           resp_rdata_r, resp_rdata_s;
   logic [1:0]            resp_cause_r, resp_cause_s;
   logic                  timeout_hit_s;

   assign acc_mask_s    = lane_mask(bus.req_type_i, bus.req_addr_i[1:0]);
   assign acc_base_s    = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign acc_wrot_s    = rot_word(bus.req_wdata_i, bus.req_addr_i[1:0]);
   assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (tcnt_r == 32'(TIMEOUT_CYCLES - 32'd1));

   // The response cycle also accepts the next request, giving one request per two cycles.
   assign bus.req_ready_o      = (state_r == IDLE) || (state_r == RESP);
   assign bus.dmem_valid_o     = dmem_valid_r;
   assign bus.dmem_addr_o      = dmem_addr_r;
   assign bus.dmem_wdata_o     = dmem_wdata_r;
   assign bus.dmem_we_o        = dmem_we_r;
   assign bus.resp_valid_o     = resp_valid_r;
   assign bus.resp_rdata_o     = resp_rdata_r;
   assign bus.resp_err_o       = resp_err_r;
   assign bus.resp_err_cause_o = resp_cause_r;

   // Next-state and next-output decode for the request/beat/response sequence.
   always_comb begin
      state_s      = state_r;
      we_s         = we_r;
      sext_s       = sext_r;
      type_s       = type_r;
      k_s          = k_r;
      mask_s       = mask_r;
      base_s       = base_r;
      rd0_s        = rd0_r;
      tcnt_s       = tcnt_r;
      dmem_valid_s = dmem_valid_r;
      dmem_addr_s  = dmem_addr_r;
      dmem_wdata_s = dmem_wdata_r;
      dmem_we_s    = dmem_we_r;
      resp_valid_s = 1'b0;
      resp_err_s   = resp_err_r;
      resp_rdata_s = resp_rdata_r;
      resp_cause_s = resp_cause_r;
      case (state_r)
         IDLE, RESP: begin
            if (bus.req_valid_i) begin
               we_s   = bus.req_we_i;
               sext_s = bus.req_sign_extend_i;
               type_s = bus.req_type_i;
               k_s    = bus.req_addr_i[1:0];
               mask_s = acc_mask_s;
               base_s = acc_base_s;
               if (acc_mask_s == 8'h00) begin
                  state_s      = RESP;
                  resp_valid_s = 1'b1;
                  resp_err_s   = 1'b1;
                  resp_rdata_s = 32'h0000_0000;
                  resp_cause_s = CAUSE_INVALID;
               end else if (!SPLIT_MISALIGNED && (acc_mask_s[7:4] != 4'h0)) begin
                  state_s      = RESP;
                  resp_valid_s = 1'b1;
                  resp_err_s   = 1'b1;
                  resp_rdata_s = 32'h0000_0000;
                  resp_cause_s = CAUSE_MISALIGN;
               end else begin
                  state_s      = BEAT0;
                  tcnt_s       = 32'd0;
                  dmem_valid_s = 1'b1;
                  dmem_addr_s  = acc_base_s;
                  dmem_wdata_s = acc_wrot_s;
                  dmem_we_s    = bus.req_we_i ? acc_mask_s[3:0] : 4'h0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BEAT0, BEAT1: begin
            if (bus.dmem_ready_i) begin
               if ((state_r == BEAT0) && (mask_r[7:4] != 4'h0)) begin
                  state_s     = BEAT1;
                  rd0_s       = bus.dmem_rdata_i;
                  tcnt_s      = 32'd0;
                  dmem_addr_s = base_r + ADDR_WIDTH'(4);
                  dmem_we_s   = we_r ? mask_r[7:4] : 4'h0;
               end else begin
                  state_s      = RESP;
                  dmem_valid_s = 1'b0;
                  resp_valid_s = 1'b1;
                  resp_err_s   = 1'b0;
                  resp_cause_s = CAUSE_NONE;
                  if (we_r) begin
                     resp_rdata_s = 32'h0000_0000;
                  end else if (state_r == BEAT0) begin
                     resp_rdata_s = load_extract(32'h0000_0000, bus.dmem_rdata_i, k_r, type_r, sext_r);
                  end else begin
                     resp_rdata_s = load_extract(bus.dmem_rdata_i, rd0_r, k_r, type_r, sext_r);
                  end
               end
            end else if (timeout_hit_s) begin
               // A first beat already written stays written; only the error is reported.
               state_s      = RESP;
               dmem_valid_s = 1'b0;
               resp_valid_s = 1'b1;
               resp_err_s   = 1'b1;
               resp_rdata_s = 32'h0000_0000;
               resp_cause_s = CAUSE_TIMEOUT;
            end else begin
               tcnt_s = tcnt_r + 32'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched request fields, beat bookkeeping and registered bus/response outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_r         <= 1'b0;
         sext_r       <= 1'b0;
         type_r       <= 2'b00;
         k_r          <= 2'b00;
         mask_r       <= 8'h00;
         base_r       <= '0;
         rd0_r        <= 32'h0000_0000;
         tcnt_r       <= 32'd0;
         dmem_valid_r <= 1'b0;
         dmem_addr_r  <= '0;
         dmem_wdata_r <= 32'h0000_0000;
         dmem_we_r    <= 4'h0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_cause_r <= 2'b00;
      end else begin
         we_r         <= we_s;
         sext_r       <= sext_s;
         type_r       <= type_s;
         k_r          <= k_s;
         mask_r       <= mask_s;
         base_r       <= base_s;
         rd0_r        <= rd0_s;
         tcnt_r       <= tcnt_s;
         dmem_valid_r <= dmem_valid_s;
         dmem_addr_r  <= dmem_addr_s;
         dmem_wdata_r <= dmem_wdata_s;
         dmem_we_r    <= dmem_we_s;
         resp_valid_r <= resp_valid_s;
         resp_err_r   <= resp_err_s;
         resp_rdata_r <= resp_rdata_s;
         resp_cause_r <= resp_cause_s;
      end
   end
endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: one instance splits with a 4-cycle timeout, a second rejects
// word-crossing accesses. Expected values are hand-computed constants.
module tb_lsu_split;
   localparam logic [1:0] T_WORD = 2'b00;
   localparam logic [1:0] T_HALF = 2'b01;
   localparam logic [1:0] T_BYTE = 2'b10;

   logic clk_s = 1'b0;
   logic rst_n_s;
   int   checks_cnt   = 0;
   int   failures_cnt = 0;
   int   b_valid_cnt  = 0;

   always #5 clk_s = ~clk_s;

   lsu_split_if #(.ADDR_WIDTH(32)) bus_a ();
   lsu_split_if #(.ADDR_WIDTH(32)) bus_b ();

   lsu_split #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_s), .rst_ni(rst_n_s), .bus(bus_a.slave));
   lsu_split #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0), .TIMEOUT_CYCLES(0)) dut_ns (
      .clk_i(clk_s), .rst_ni(rst_n_s), .bus(bus_b.slave));

   // Counts memory beats requested by the non-splitting instance.
   always @(posedge clk_s) begin
      if (bus_b.dmem_valid_o) b_valid_cnt <= b_valid_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_s);
      #1;
   endtask

   task automatic issue_a(input logic we, input logic [1:0] typ, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus_a.req_valid_i = 1'b1;
      bus_a.req_we_i = we;
      bus_a.req_type_i = typ;
      bus_a.req_sign_extend_i = sext;
      bus_a.req_addr_i = addr;
      bus_a.req_wdata_i = wdata;
      step();
      bus_a.req_valid_i = 1'b0;
   endtask

   task automatic beat_a(input string tag, input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] wdata, input logic [31:0] rdata);
      check({tag, ".dvalid"}, 32'(bus_a.dmem_valid_o), 32'd1);
      check({tag, ".daddr"}, bus_a.dmem_addr_o, addr);
      check({tag, ".dwe"}, 32'(bus_a.dmem_we_o), 32'(we));
      check({tag, ".dwdata"}, bus_a.dmem_wdata_o, wdata);
      bus_a.dmem_ready_i = 1'b1;
      bus_a.dmem_rdata_i = rdata;
      step();
      bus_a.dmem_ready_i = 1'b0;
      bus_a.dmem_rdata_i = 32'h0;
   endtask

   task automatic resp_a(input string tag, input logic [31:0] rdata, input logic err,
                         input logic [1:0] cause);
      check({tag, ".rvalid"}, 32'(bus_a.resp_valid_o), 32'd1);
      check({tag, ".rdata"}, bus_a.resp_rdata_o, rdata);
      check({tag, ".err"}, 32'(bus_a.resp_err_o), 32'(err));
      check({tag, ".cause"}, 32'(bus_a.resp_err_cause_o), 32'(cause));
      check({tag, ".dvalid_off"}, 32'(bus_a.dmem_valid_o), 32'd0);
      check({tag, ".ready"}, 32'(bus_a.req_ready_o), 32'd1);
      step();
      check({tag, ".pulse_end"}, 32'(bus_a.resp_valid_o), 32'd0);
      check({tag, ".rdata_hold"}, bus_a.resp_rdata_o, rdata);
   endtask

   initial begin
      int vcnt;
      int seen;
      rst_n_s = 1'b0;
      bus_a.req_valid_i = 1'b0; bus_a.req_we_i = 1'b0; bus_a.req_type_i = 2'b00;
      bus_a.req_sign_extend_i = 1'b0; bus_a.req_addr_i = 32'h0; bus_a.req_wdata_i = 32'h0;
      bus_a.dmem_ready_i = 1'b0; bus_a.dmem_rdata_i = 32'h0;
      bus_b.req_valid_i = 1'b0; bus_b.req_we_i = 1'b0; bus_b.req_type_i = 2'b00;
      bus_b.req_sign_extend_i = 1'b0; bus_b.req_addr_i = 32'h0; bus_b.req_wdata_i = 32'h0;
      bus_b.dmem_ready_i = 1'b0; bus_b.dmem_rdata_i = 32'h0;
      step();
      step();
      check("rst.ready", 32'(bus_a.req_ready_o), 32'd1);
      check("rst.dvalid", 32'(bus_a.dmem_valid_o), 32'd0);
      check("rst.rvalid", 32'(bus_a.resp_valid_o), 32'd0);
      check("rst.rdata", bus_a.resp_rdata_o, 32'h0);
      rst_n_s = 1'b1;
      step();

      // Aligned word load
      issue_a(1'b0, T_WORD, 1'b0, 32'h0000_0100, 32'h0);
      beat_a("lw", 32'h0000_0100, 4'b0000, 32'h0, 32'hDEAD_BEEF);
      resp_a("lw", 32'hDEAD_BEEF, 1'b0, 2'd0);

      // Signed and unsigned byte loads from lane 3
      issue_a(1'b0, T_BYTE, 1'b1, 32'h0000_0103, 32'h0);
      beat_a("lbs", 32'h0000_0100, 4'b0000, 32'h0, 32'h80FF_0000);
      resp_a("lbs", 32'hFFFF_FF80, 1'b0, 2'd0);
      issue_a(1'b0, T_BYTE, 1'b0, 32'h0000_0103, 32'h0);
      beat_a("lbu", 32'h0000_0100, 4'b0000, 32'h0, 32'h80FF_0000);
      resp_a("lbu", 32'h0000_0080, 1'b0, 2'd0);

      // Split word store
      issue_a(1'b1, T_WORD, 1'b0, 32'h0000_0202, 32'h1122_3344);
      beat_a("sw0", 32'h0000_0200, 4'b1100, 32'h3344_1122, 32'h0);
      beat_a("sw1", 32'h0000_0204, 4'b0011, 32'h3344_1122, 32'h0);
      resp_a("sw", 32'h0, 1'b0, 2'd0);

      // Byte store into lane 1
      issue_a(1'b1, T_BYTE, 1'b0, 32'h0000_0101, 32'h0000_00AA);
      beat_a("sb", 32'h0000_0100, 4'b0010, 32'h0000_AA00, 32'h0);
      resp_a("sb", 32'h0, 1'b0, 2'd0);

      // Split halfword load wrapping to address 0
      issue_a(1'b0, T_HALF, 1'b0, 32'hFFFF_FFFF, 32'h0);
      beat_a("lhw0", 32'hFFFF_FFFC, 4'b0000, 32'h0, 32'hAB00_0000);
      beat_a("lhw1", 32'h0000_0000, 4'b0000, 32'h0, 32'h0000_00CD);
      resp_a("lhw", 32'h0000_CDAB, 1'b0, 2'd0);

      // Halfword at offset 1 stays in one word
      issue_a(1'b0, T_HALF, 1'b1, 32'h0000_0101, 32'h0);
      beat_a("lh1", 32'h0000_0100, 4'b0000, 32'h0, 32'h12BE_EF34);
      resp_a("lh1", 32'hFFFF_BEEF, 1'b0, 2'd0);

      // Invalid access type
      issue_a(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
      resp_a("inval", 32'h0, 1'b1, 2'd3);

      // Non-splitting instance: word-crossing reject, then a legal halfword at offset 1
      bus_b.req_valid_i = 1'b1; bus_b.req_type_i = T_WORD; bus_b.req_addr_i = 32'h0000_0001;
      step();
      bus_b.req_valid_i = 1'b0;
      check("mis.rvalid", 32'(bus_b.resp_valid_o), 32'd1);
      check("mis.err", 32'(bus_b.resp_err_o), 32'd1);
      check("mis.cause", 32'(bus_b.resp_err_cause_o), 32'd1);
      check("mis.rdata", bus_b.resp_rdata_o, 32'h0);
      step();
      check("mis.no_beat", 32'(b_valid_cnt), 32'd0);
      bus_b.req_valid_i = 1'b1; bus_b.req_type_i = T_HALF; bus_b.req_addr_i = 32'h0000_0101;
      step();
      bus_b.req_valid_i = 1'b0;
      check("nsh.dvalid", 32'(bus_b.dmem_valid_o), 32'd1);
      check("nsh.daddr", bus_b.dmem_addr_o, 32'h0000_0100);
      bus_b.dmem_ready_i = 1'b1; bus_b.dmem_rdata_i = 32'h12BE_EF34;
      step();
      bus_b.dmem_ready_i = 1'b0;
      check("nsh.rvalid", 32'(bus_b.resp_valid_o), 32'd1);
      check("nsh.rdata", bus_b.resp_rdata_o, 32'h0000_BEEF);
      check("nsh.err", 32'(bus_b.resp_err_o), 32'd0);

      // Stalled beat times out after 4 cycles of dmem_valid
      issue_a(1'b0, T_WORD, 1'b0, 32'h0000_0300, 32'h0);
      vcnt = 0;
      seen = -1;
      for (int i = 1; i <= 10 && seen < 0; i++) begin
         if (bus_a.resp_valid_o) begin
            seen = i;
         end else begin
            if (bus_a.dmem_valid_o) vcnt++;
            step();
         end
      end
      check("to.valid_cycles", 32'(vcnt), 32'd4);
      check("to.resp_cycle", 32'(seen), 32'd5);
      resp_a("to", 32'h0, 1'b1, 2'd2);

      // Reset during a stalled beat
      issue_a(1'b0, T_WORD, 1'b0, 32'h0000_0500, 32'h0);
      step();
      check("rmid.dvalid_pre", 32'(bus_a.dmem_valid_o), 32'd1);
      #2 rst_n_s = 1'b0;
      #1;
      check("rmid.ready", 32'(bus_a.req_ready_o), 32'd1);
      check("rmid.dvalid", 32'(bus_a.dmem_valid_o), 32'd0);
      check("rmid.daddr", bus_a.dmem_addr_o, 32'h0);
      check("rmid.dwdata", bus_a.dmem_wdata_o, 32'h0);
      check("rmid.dwe", 32'(bus_a.dmem_we_o), 32'd0);
      check("rmid.rvalid", 32'(bus_a.resp_valid_o), 32'd0);
      check("rmid.rdata", bus_a.resp_rdata_o, 32'h0);
      check("rmid.err", 32'(bus_a.resp_err_o), 32'd0);
      check("rmid.cause", 32'(bus_a.resp_err_cause_o), 32'd0);
      #2 rst_n_s = 1'b1;
      step();

      // Normal operation after reset
      issue_a(1'b0, T_WORD, 1'b0, 32'h0000_0400, 32'h0);
      beat_a("post", 32'h0000_0400, 4'b0000, 32'h0, 32'h0123_4567);
      resp_a("post", 32'h0123_4567, 1'b0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end
endmodule
